// File: rtl/simd_divmod_pkg.sv
// simd_divmod_pkg -- shared encodings for the sequential SIMD divide/modulo unit.
//   op_e    : operation select (DIV, MOD, SQRT, reserved)
//   ww_e    : lane width select (8/16/32/64 bits)
//   state_e : controller states
//   lw()    : lane width in bits for a WW code
package simd_divmod_pkg;

   typedef enum logic [1:0] {
      OP_DIV  = 2'b00,
      OP_MOD  = 2'b01,
      OP_SQRT = 2'b10,
      OP_RSV  = 2'b11
   } op_e;

   typedef enum logic [1:0] {
      WW_8  = 2'b00,
      WW_16 = 2'b01,
      WW_32 = 2'b10,
      WW_64 = 2'b11
   } ww_e;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      CALC = 2'b01,
      DONE = 2'b10
   } state_e;

   function automatic logic [6:0] lw(input logic [1:0] ww);
      return 7'd8 << ww;
   endfunction

endpackage

// File: rtl/simd_divmod_step.sv
// simd_divmod_step -- one combinational restoring step, 64-bit datapath.
//   rem       : partial remainder entering the step
//   root      : partial square root (sqrt mode only)
//   dvs_top   : top 64 bits of the divisor shift register; the lane divisor
//               sits in its most-significant lw bits
//   din       : next dividend bits, MSB first (div uses din[1] only)
//   lw        : lane width in bits
//   sqrt_mode : 1 = sqrt digit step (two radicand bits), 0 = divide step
//   rem_nxt   : partial remainder after the step
//   qbit      : quotient / root bit produced by the step
module simd_divmod_step
   import simd_divmod_pkg::*;
(
   input  logic [63:0] rem,
   input  logic [63:0] root,
   input  logic [63:0] dvs_top,
   input  logic [1:0]  din,
   input  logic [6:0]  lw,
   input  logic        sqrt_mode,
   output logic [63:0] rem_nxt,
   output logic        qbit
);

   logic [63:0] dvs;
   logic [65:0] shifted;
   logic [65:0] sub;

   // Shifted remainder carries extra headroom: rem < divisor can still
   // exceed lw bits once a new bit is appended.
   always_comb begin
      dvs = dvs_top >> (7'd64 - lw);
      if (sqrt_mode) begin
         shifted = {rem, din};
         sub     = {root, 2'b01};
      end else begin
         shifted = {1'b0, rem, din[1]};
         sub     = {2'b00, dvs};
      end
      qbit    = (shifted >= sub);
      rem_nxt = 64'(qbit ? shifted - sub : shifted);
   end

endmodule

// File: rtl/simd_divmod_seq.sv
// simd_divmod_seq -- sequential SIMD unsigned divide/modulo (optional sqrt).
// Lanes are processed MS lane first through one restoring step per cycle.
//   clk, rst_n          : clock, async active-low reset
//   in_valid/in_ready   : request handshake (ready only in IDLE)
//   rA_val, rB_val      : dividend / divisor vectors, bit 0 = MSB, lane 0 at MS end
//   op, WW              : operation and lane width select
//   flush               : synchronous abort
//   out_valid/out_ready : result handshake
//   result              : per-lane result
//   div_zero            : per-lane divisor-zero flags (bit 0 = lane 0)
//   op_err              : reserved or disabled op requested
// Macro SIMD_DIVMOD_SQRT_EN enables op 10 (floor square root, LW/2 steps per lane).
module simd_divmod_seq
   import simd_divmod_pkg::*;
#(
   parameter int DATA_W = 64
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [0:DATA_W-1] rA_val,
   input  logic [0:DATA_W-1] rB_val,
   input  logic [0:1]        op,
   input  logic [0:1]        WW,
   input  logic              flush,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [0:DATA_W-1] result,
   output logic [0:DATA_W/8-1] div_zero,
   output logic              op_err
);

   localparam int NB  = DATA_W / 8;
   localparam int LCW = $clog2(NB);

`ifdef SIMD_DIVMOD_SQRT_EN
   localparam bit SQRT_EN = 1'b1;
`else
   localparam bit SQRT_EN = 1'b0;
`endif

   state_e            state;
   op_e               op_q;
   logic [1:0]        ww_q;
   logic [DATA_W-1:0] opa, opb, res;
   logic [63:0]       rem, q;
   logic [6:0]        step_cnt;
   logic [LCW-1:0]    lane_cnt;

   op_e               op_in;
   logic [1:0]        ww_in;
   logic [DATA_W-1:0] b_in;
   logic [NB-1:0]     bz;
   logic [3:0][NB-1:0] lz;

   logic [6:0]  lw_q, step_last;
   logic        sqrt_mode, lane_end, lane_last;
   logic [63:0] lane_mask, lane_val, rem_nxt, q_nxt;
   logic        qbit;

   assign op_in  = op_e'(op);
   assign ww_in  = WW;
   assign b_in   = rB_val;
   assign result = res;

   // Zero-divisor detection: per byte (counted from the MS end), then
   // combined per lane for each of the four widths.
   for (genvar k = 0; k < NB; k++) begin : g_bz
      assign bz[k] = (b_in[DATA_W-1-8*k -: 8] == 8'd0);
   end
   for (genvar w = 0; w < 4; w++) begin : g_w
      for (genvar i = 0; i < NB; i++) begin : g_l
         if (i < (NB >> w)) begin : g_on
            assign lz[w][i] = &bz[i*(1<<w) +: (1<<w)];
         end else begin : g_off
            assign lz[w][i] = 1'b0;
         end
      end
   end

   always_comb begin
      lw_q      = lw(ww_q);
      sqrt_mode = SQRT_EN && (op_q == OP_SQRT);
      step_last = sqrt_mode ? (lw_q >> 1) - 7'd1 : lw_q - 7'd1;
      lane_end  = (step_cnt == step_last);
      lane_last = (lane_cnt == LCW'((NB >> ww_q) - 1));
      lane_mask = {64{1'b1}} >> (7'd64 - lw_q);
      q_nxt     = 64'({q, qbit});
      case (op_q)
         OP_DIV:  lane_val = q_nxt;
         OP_MOD:  lane_val = rem_nxt;
         OP_SQRT: lane_val = SQRT_EN ? q_nxt : 64'd0;
         default: lane_val = 64'd0;
      endcase
   end

   simd_divmod_step u_step (
      .rem       (rem),
      .root      (q),
      .dvs_top   (opb[DATA_W-1 -: 64]),
      .din       (opa[DATA_W-1 -: 2]),
      .lw        (lw_q),
      .sqrt_mode (sqrt_mode),
      .rem_nxt   (rem_nxt),
      .qbit      (qbit)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         res       <= '0;
         div_zero  <= '0;
         op_err    <= 1'b0;
         opa       <= '0;
         opb       <= '0;
         rem       <= '0;
         q         <= '0;
         step_cnt  <= '0;
         lane_cnt  <= '0;
         op_q      <= OP_DIV;
         ww_q      <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid && !flush) begin
                  state    <= CALC;
                  in_ready <= 1'b0;
                  opa      <= rA_val;
                  opb      <= rB_val;
                  op_q     <= op_in;
                  ww_q     <= ww_in;
                  res      <= '0;
                  rem      <= '0;
                  q        <= '0;
                  step_cnt <= '0;
                  lane_cnt <= '0;
                  op_err   <= (op_in == OP_RSV) || (op_in == OP_SQRT && !SQRT_EN);
                  for (int i = 0; i < NB; i++)
                     div_zero[i] <= (op_in == OP_DIV || op_in == OP_MOD) && lz[ww_in][i];
               end
            end
            CALC: begin
               if (flush) begin
                  state    <= IDLE;
                  in_ready <= 1'b1;
                  res      <= '0;
                  div_zero <= '0;
                  op_err   <= 1'b0;
               end else begin
                  rem      <= lane_end ? 64'd0 : rem_nxt;
                  q        <= lane_end ? 64'd0 : q_nxt;
                  opa      <= sqrt_mode ? (opa << 2) : (opa << 1);
                  step_cnt <= lane_end ? 7'd0 : step_cnt + 7'd1;
                  if (lane_end) begin
                     // Result fills from the LS end; after NL lanes lane 0 is at the MS end.
                     res      <= (res << lw_q) | DATA_W'(lane_val & lane_mask);
                     opb      <= opb << lw_q;
                     lane_cnt <= lane_last ? '0 : lane_cnt + LCW'(1);
                     if (lane_last) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                     end
                  end
               end
            end
            DONE: begin
               if (flush) begin
                  state     <= IDLE;
                  in_ready  <= 1'b1;
                  out_valid <= 1'b0;
                  res       <= '0;
                  div_zero  <= '0;
                  op_err    <= 1'b0;
               end else if (out_ready) begin
                  state     <= IDLE;
                  in_ready  <= 1'b1;
                  out_valid <= 1'b0;
               end
            end
            default: begin
               state    <= IDLE;
               in_ready <= 1'b1;
            end
         endcase
      end
   end

endmodule
